dht_read_sched: RTL and testbench

- Controller and scheduler for the single-wire DHT-class humidity/temperature sensor on `I_O_sda`.
- Issues the start pulse, then decodes the 40-bit frame with an explicit state machine and per-phase timeouts.
- Verifies the checksum, retries on failure, and enforces the sensor's minimum inter-read gap.
- Serves both on-demand host requests and free-running auto mode. Sits between the SDA pad and the display/number-formatting logic.

---
 rtl/dht_read_sched.sv | 220 ++++++++++++++++++++++
 tb/tb_dht_read_sched.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dht_read_sched.sv
// Single-wire DHT-class sensor controller: start pulse, 40-bit frame decode with
// per-phase timeouts, checksum check, bounded retries and a minimum inter-read gap.
module dht_read_sched #(
  parameter int CLK_FREQ_HZ   = 100_000_000,
  parameter int START_LOW_US  = 18_000,
  parameter int MIN_GAP_US    = 2_000_000,
  parameter int BIT_THRESH_US = 50,
  parameter int TIMEOUT_US    = 200,
  parameter int MAX_RETRY     = 3
) (
  input  logic        I_clk,
  input  logic        I_rst_n,
  input  logic        I_req,
  input  logic        I_auto_en,
  inout  wire         I_O_sda,
  output logic        O_busy,
  output logic        O_done,
  output logic        O_valid,
  output logic        O_err,
  output logic [1:0]  O_err_code,
  output logic [15:0] O_humidity,
  output logic [15:0] O_temperature
);

  localparam int TICK_DIV = (CLK_FREQ_HZ >= 2_000_000) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int US_MAX   = (START_LOW_US > TIMEOUT_US) ? START_LOW_US : TIMEOUT_US;
  localparam int UW       = $clog2(US_MAX + 1);
  localparam int GW       = $clog2(MIN_GAP_US + 1);
  localparam int RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [UW-1:0] START_LAST = UW'(START_LOW_US - 1);
  localparam logic [UW-1:0] TMO_LAST   = UW'(TIMEOUT_US - 1);
  localparam logic [UW-1:0] THRESH     = UW'(BIT_THRESH_US);
  localparam logic [UW-1:0] US_SAT     = '1;
  localparam logic [GW-1:0] GAP_DONE   = GW'(MIN_GAP_US);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(MAX_RETRY);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_START      = 4'd1;
  localparam logic [3:0] S_WAIT_ACK_L = 4'd2;
  localparam logic [3:0] S_ACK_L      = 4'd3;
  localparam logic [3:0] S_ACK_H      = 4'd4;
  localparam logic [3:0] S_BIT_L      = 4'd5;
  localparam logic [3:0] S_BIT_H      = 4'd6;
  localparam logic [3:0] S_CHECK      = 4'd7;

  logic          tick;
  logic [2:0]    sync_q;
  logic          sda_rise, sda_fall, tmo;
  logic [3:0]    state_q, state_d;
  logic [UW-1:0] us_q, us_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pend_q, pend_d, force_q, force_d;
  logic [5:0]    bitcnt_q, bitcnt_d;
  logic [39:0]   frame_q, frame_d;
  logic          done_q, done_d, valid_q, valid_d, err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic [15:0]   hum_q, hum_d, temp_q, temp_d;
  logic          fail;
  logic [1:0]    fail_code;
  logic [7:0]    csum;

  generate
    if (TICK_DIV == 1) begin : g_no_pre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
      logic [PW-1:0] pre_q;
      always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n)              pre_q <= '0;
        else if (pre_q == PRE_LAST) pre_q <= '0;
        else                       pre_q <= pre_q + 1'b1;
      end
      assign tick = (pre_q == PRE_LAST);
    end
  endgenerate

  // sync_q[1] is the synchronized line, sync_q[2] its previous value
  assign sda_rise = sync_q[1] & ~sync_q[2];
  assign sda_fall = ~sync_q[1] & sync_q[2];
  assign tmo      = tick && (us_q >= TMO_LAST);
  assign csum     = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

  always_comb begin
    state_d   = state_q;
    us_d      = us_q;
    gap_d     = gap_q;
    retry_d   = retry_q;
    pend_d    = pend_q | I_req;
    force_d   = force_q;
    bitcnt_d  = bitcnt_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    valid_d   = valid_q;
    err_d     = err_q;
    code_d    = code_q;
    hum_d     = hum_q;
    temp_d    = temp_q;
    fail      = 1'b0;
    fail_code = 2'b00;
    if (tick && us_q != US_SAT) us_d = us_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick && gap_q != GAP_DONE) gap_d = gap_q + 1'b1;
        if (gap_q == GAP_DONE && (pend_q || I_auto_en || force_q)) begin
          state_d = S_START;
          pend_d  = 1'b0;
          force_d = 1'b0;
        end
      end
      S_START: if (tick && us_q >= START_LAST) state_d = S_WAIT_ACK_L;
      S_WAIT_ACK_L: begin
        if (sda_fall) state_d = S_ACK_L;
        else if (tmo) begin fail = 1'b1; fail_code = 2'b01; end
      end
      S_ACK_L: begin
        if (sda_rise) state_d = S_ACK_H;
        else if (tmo) begin fail = 1'b1; fail_code = 2'b01; end
      end
      S_ACK_H: begin
        if (sda_fall) begin state_d = S_BIT_L; bitcnt_d = '0; end
        else if (tmo) begin fail = 1'b1; fail_code = 2'b01; end
      end
      S_BIT_L: begin
        if (sda_rise) state_d = S_BIT_H;
        else if (tmo) begin fail = 1'b1; fail_code = 2'b10; end
      end
      S_BIT_H: begin
        if (sda_fall) begin
          frame_d  = {frame_q[38:0], (us_q > THRESH)};
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = (bitcnt_q == 6'd39) ? S_CHECK : S_BIT_L;
        end else if (tmo) begin
          fail = 1'b1; fail_code = 2'b10;
        end
      end
      S_CHECK: begin
        if (frame_q[7:0] == csum) begin
          hum_d   = frame_q[39:24];
          temp_d  = frame_q[23:8];
          valid_d = 1'b1;
          err_d   = 1'b0;
          code_d  = 2'b00;
          done_d  = 1'b1;
          retry_d = '0;
          state_d = S_IDLE;
        end else begin
          fail = 1'b1; fail_code = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A retry re-enters IDLE silently and restarts once the gap has elapsed
    if (fail) begin
      state_d = S_IDLE;
      if (retry_q < RETRY_LIM) begin
        retry_d = retry_q + 1'b1;
        force_d = 1'b1;
      end else begin
        done_d  = 1'b1;
        valid_d = 1'b0;
        err_d   = 1'b1;
        code_d  = fail_code;
        retry_d = '0;
      end
    end
    if (state_d != state_q) us_d = '0;
    if (state_d == S_IDLE && state_q != S_IDLE) gap_d = '0;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sync_q   <= 3'b111;
      state_q  <= S_IDLE;
      us_q     <= '0;
      gap_q    <= '0;
      retry_q  <= '0;
      pend_q   <= 1'b0;
      force_q  <= 1'b0;
      bitcnt_q <= '0;
      frame_q  <= '0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      hum_q    <= '0;
      temp_q   <= '0;
    end else begin
      sync_q   <= {sync_q[1:0], I_O_sda};
      state_q  <= state_d;
      us_q     <= us_d;
      gap_q    <= gap_d;
      retry_q  <= retry_d;
      pend_q   <= pend_d;
      force_q  <= force_d;
      bitcnt_q <= bitcnt_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      code_q   <= code_d;
      hum_q    <= hum_d;
      temp_q   <= temp_d;
    end
  end

  assign I_O_sda       = (state_q == S_START) ? 1'b0 : 1'bz;
  assign O_busy        = (state_q != S_IDLE);
  assign O_done        = done_q;
  assign O_valid       = valid_q;
  assign O_err         = err_q;
  assign O_err_code    = code_q;
  assign O_humidity    = hum_q;
  assign O_temperature = temp_q;

endmodule

// File: tb/tb_dht_read_sched.sv
// Randomized scoreboard bench for dht_read_sched with a behavioural sensor model
// on the open-drain line and an outcome model per host transaction.
`timescale 1ns/1ps
module tb_dht_read_sched;

  localparam int START_US = 20;
  localparam int GAP_US   = 500;
  localparam int RETRY    = 3;
  localparam int K_FULL   = 0;
  localparam int K_NONE   = 1;
  localparam int K_TRUNC  = 2;

  typedef struct { int kind; logic [39:0] frame; int nbits; } att_t;
  typedef struct {
    logic valid; logic err; logic [1:0] code;
    logic [15:0] hum; logic [15:0] temp; int att;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0, auto_en = 1'b0, sen_low = 1'b0;
  wire  sda;
  logic busy, done, valid, err;
  logic [1:0]  code;
  logic [15:0] hum, temp;

  pullup (sda);
  assign sda = sen_low ? 1'b0 : 1'bz;

  dht_read_sched #(
    .CLK_FREQ_HZ(1_000_000), .START_LOW_US(START_US), .MIN_GAP_US(GAP_US),
    .BIT_THRESH_US(50), .TIMEOUT_US(200), .MAX_RETRY(RETRY)
  ) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_req(req), .I_auto_en(auto_en), .I_O_sda(sda),
    .O_busy(busy), .O_done(done), .O_valid(valid), .O_err(err), .O_err_code(code),
    .O_humidity(hum), .O_temperature(temp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_fail = 0;
  int done_cnt = 0, total_starts = 0, starts_since_done = 0;
  int last_start_cyc = 0, last_done_cyc = 0;
  bit gap_chk = 1'b0, abort_start = 1'b0, in_high = 1'b0;
  att_t plan_q[$], stage_q[$];
  exp_t exp_q[$];
  logic [15:0] m_hum = '0, m_temp = '0;

  task automatic chk_eq(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic [39:0] make_frame(input logic [15:0] h, input logic [15:0] t, input bit corrupt);
    int s;
    s = (int'(h) / 256) + (int'(h) % 256) + (int'(t) / 256) + (int'(t) % 256) + (corrupt ? 1 : 0);
    return {h, t, 8'(s % 256)};
  endfunction

  function automatic bit frame_ok(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) == int'(f[7:0]);
  endfunction

  task automatic stage(input int kind, input logic [39:0] f, input int nb);
    att_t a;
    a.kind = kind; a.frame = f; a.nbits = nb;
    stage_q.push_back(a);
  endtask

  // Outcome model: the first fully received, checksum-correct frame among the
  // first 1+RETRY attempts wins; otherwise the last attempt's cause is reported.
  task automatic commit_txn();
    exp_t e;
    bit ok;
    int n;
    logic [1:0] cause;
    ok = 1'b0; n = 0; cause = 2'b00;
    foreach (stage_q[i]) begin
      if (!ok && n < RETRY + 1) begin
        n++;
        plan_q.push_back(stage_q[i]);
        if (stage_q[i].kind == K_NONE)       cause = 2'b01;
        else if (stage_q[i].kind == K_TRUNC) cause = 2'b10;
        else if (!frame_ok(stage_q[i].frame)) cause = 2'b11;
        else begin
          ok = 1'b1;
          m_hum  = stage_q[i].frame[39:24];
          m_temp = stage_q[i].frame[23:8];
        end
      end
    end
    e.valid = ok; e.err = !ok; e.code = ok ? 2'b00 : cause;
    e.hum = m_hum; e.temp = m_temp; e.att = n;
    exp_q.push_back(e);
    stage_q.delete();
  endtask

  task automatic drive(input int n, input bit low);
    sen_low = low;
    repeat (n) @(negedge clk);
  endtask

  // Sensor model: detects the host start pulse, then answers per the plan queue
  initial begin : sensor
    int w, sc;
    att_t a;
    forever begin
      @(negedge clk);
      if (sda === 1'b0 && !sen_low) begin
        sc = cyc;
        chk_eq("busy_at_start", busy, 1);
        w = 0;
        while (sda === 1'b0 && w < 100000) begin
          w++;
          @(negedge clk);
        end
        starts_since_done++;
        total_starts++;
        if (abort_start) begin
          abort_start = 1'b0;
        end else begin
          chk_rng("start_low_us", w, START_US, START_US);
          chk_rng("start_spacing", sc - last_start_cyc, GAP_US, 1 << 30);
          if (gap_chk) chk_rng("idle_gap", sc - last_done_cyc, GAP_US, GAP_US + 3);
          chk_rng("plan_available", plan_q.size(), 1, 1 << 30);
          if (plan_q.size() > 0) begin
            a = plan_q.pop_front();
            if (a.kind != K_NONE) begin
              drive(20, 1'b0); drive(80, 1'b1); drive(80, 1'b0);
              for (int i = 39; i >= 0; i--) begin
                drive(30, 1'b1);
                in_high = 1'b1;
                drive(a.frame[i] ? 70 : 26, 1'b0);
                in_high = 1'b0;
                if (a.kind == K_TRUNC && (40 - i) >= a.nbits) break;
              end
              if (a.kind == K_FULL) drive(30, 1'b1);
              sen_low = 1'b0;
            end
          end
        end
        last_start_cyc = sc;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done: got done at cycle %0d, want none", cyc);
        end else begin
          e = exp_q.pop_front();
          $display("txn %0d: valid=%0b err=%0b code=%0d hum=%h temp=%h attempts=%0d",
                   done_cnt, valid, err, code, hum, temp, starts_since_done);
          chk_eq("valid", valid, e.valid);
          chk_eq("err", err, e.err);
          chk_eq("err_code", code, e.code);
          chk_eq("humidity", hum, e.hum);
          chk_eq("temperature", temp, e.temp);
          chk_rng("attempts", starts_since_done, e.att, e.att);
        end
        starts_since_done = 0;
        last_done_cyc = cyc;
        @(negedge clk);
        chk_eq("done_one_cycle", done, 0);
      end
    end
  end

  initial begin : watchdog
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got no completion by cycle %0d, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_req();
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
  endtask

  task automatic wait_dones_to(input int tgt, input int budget);
    int c;
    c = 0;
    while (done_cnt < tgt && c < budget) begin @(negedge clk); c++; end
    chk_rng("done_count", done_cnt, tgt, tgt);
  endtask

  task automatic wait_starts_to(input int tgt, input int budget);
    int c;
    c = 0;
    while (total_starts < tgt && c < budget) begin @(negedge clk); c++; end
    chk_rng("start_count", total_starts, tgt, tgt);
  endtask

  task automatic stage_good_random();
    stage(K_FULL, make_frame(16'($urandom), 16'($urandom), 1'b0), 40);
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_sda"}, sda, 1);
    chk_eq({tag, "_busy"}, busy, 0);
    chk_eq({tag, "_done"}, done, 0);
    chk_eq({tag, "_valid"}, valid, 0);
    chk_eq({tag, "_err"}, err, 0);
    chk_eq({tag, "_code"}, code, 0);
    chk_eq({tag, "_hum"}, hum, 0);
    chk_eq({tag, "_temp"}, temp, 0);
  endtask

  initial begin : stim
    int d0, s0, c, nf;
    logic [15:0] h, t;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    last_start_cyc = cyc;

    // Reference frame from the datasheet example
    stage(K_FULL, 40'h028C015FEE, 40);
    commit_txn(); d0 = done_cnt; pulse_req(); wait_dones_to(d0 + 1, 8000);

    repeat (RETRY + 1) stage(K_NONE, '0, 0);
    commit_txn(); d0 = done_cnt; pulse_req(); wait_dones_to(d0 + 1, 8000);

    repeat (RETRY + 1) stage(K_FULL, 40'h028C015FEF, 40);
    commit_txn(); d0 = done_cnt; pulse_req(); wait_dones_to(d0 + 1, 25000);

    h = 16'($urandom); t = 16'($urandom);
    stage(K_FULL, make_frame(h, t, 1'b1), 40);
    stage(K_FULL, make_frame(h, t, 1'b0), 40);
    commit_txn(); d0 = done_cnt; pulse_req(); wait_dones_to(d0 + 1, 12000);

    // Request while a data bit is being received
    stage_good_random(); commit_txn();
    stage_good_random(); commit_txn();
    d0 = done_cnt; pulse_req();
    c = 0;
    while (!in_high && c < 3000) begin @(negedge clk); c++; end
    chk_rng("bit_high_seen", c, 0, 2999);
    gap_chk = 1'b1;
    pulse_req();
    wait_dones_to(d0 + 2, 12000);
    gap_chk = 1'b0;

    // Auto mode, with a coincident request that must not add a transaction
    stage_good_random(); commit_txn();
    stage_good_random(); commit_txn();
    d0 = done_cnt; s0 = total_starts;
    @(negedge clk); auto_en = 1'b1; req = 1'b1;
    @(negedge clk); req = 1'b0;
    wait_starts_to(s0 + 1, 3000);
    gap_chk = 1'b1;
    wait_starts_to(s0 + 2, 6000);
    auto_en = 1'b0;
    wait_dones_to(d0 + 2, 6000);
    gap_chk = 1'b0;
    s0 = total_starts;
    repeat (1500) @(negedge clk);
    chk_rng("no_extra_start", total_starts, s0, s0);

    // Reset in the middle of the start pulse
    abort_start = 1'b1;
    pulse_req();
    c = 0;
    while (sda !== 1'b0 && c < 2000) begin @(negedge clk); c++; end
    chk_rng("reset_test_start_seen", c, 0, 1999);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_hum = '0; m_temp = '0;
    starts_since_done = 0;
    last_start_cyc = cyc;
    stage_good_random(); commit_txn();
    d0 = done_cnt; pulse_req(); wait_dones_to(d0 + 1, 8000);

    // Random attempts: optional early failure followed by a good frame
    for (int k = 0; k < 3; k++) begin
      nf = $urandom_range(0, 1);
      for (int j = 0; j < nf; j++)
        stage(($urandom_range(0, 1) == 1) ? K_NONE : K_TRUNC,
              make_frame(16'($urandom), 16'($urandom), 1'b0), $urandom_range(1, 8));
      stage_good_random();
      commit_txn(); d0 = done_cnt; pulse_req(); wait_dones_to(d0 + 1, 12000);
    end

    chk_rng("expect_queue_drained", exp_q.size(), 0, 0);
    chk_rng("plan_queue_drained", plan_q.size(), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
